// File: rtl/pause_fade_pkg.sv
// pause_fade_pkg: shared types and helpers for the pause/fade block.
// Holds the FSM state encoding, the dim-level width, the counter sizing
// function and the 3:3:2 per-channel dimming helper.
package pause_fade_pkg;

    localparam int LEVEL_W = 2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        FADE = 2'd2,
        DIM  = 2'd3
    } state_t;

    // Width of the frame counter so it can hold the larger of the two frame
    // thresholds; never narrower than one bit.
    function automatic int cnt_width(input int delay_frames, input int step_frames);
        int max_frames;
        max_frames = (delay_frames > step_frames) ? delay_frames : step_frames;
        return (max_frames < 1) ? 1 : $clog2(max_frames + 1);
    endfunction

    // Shift each 3:3:2 channel right by the dim level, each keeping its own width.
    function automatic logic [7:0] dim_rgb332(input logic [7:0] rgb,
                                              input logic [LEVEL_W-1:0] shift);
        return {rgb[7:5] >> shift, rgb[4:2] >> shift, rgb[1:0] >> shift};
    endfunction

endpackage

// File: rtl/pf_frame_tick.sv
// pf_frame_tick: frame-start strobe for pause_fade.
// Emits a one-clk_sys pulse on the first ce_pix at which vblank_in is high
// after having been low at the previous ce_pix.
module pf_frame_tick (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_pix,
    input  logic vblank_in,
    output logic frame_tick
);

    logic vblank_q;

    // Remember vblank as seen at the previous pixel.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: reset as "in blanking" so a reset released during vblank
            // does not fire a spurious tick on the first pixel.
            vblank_q <= 1'b1;
        end else if (ce_pix) begin
            vblank_q <= vblank_in;
        end
    end

    assign frame_tick = ce_pix & vblank_in & ~vblank_q;

endmodule

// File: rtl/pause_fade.sv
// pause_fade: user pause toggle, combined pause output and frame-aligned
// dimming of the 3:3:2 video stream while paused. All video signals are
// re-timed by one pixel so blanking, sync and colour stay aligned.
// Optional build macro PAUSE_FADE_RAMP_EN: when defined, dimming ramps one
// level every FADE_FRAMES_PER_STEP frames; otherwise the level jumps straight
// from 0 to MAX_LEVEL when the delay expires.
module pause_fade
    import pause_fade_pkg::*;
#(
    parameter int DIM_DELAY_FRAMES     = 600,
    parameter int FADE_FRAMES_PER_STEP = 30,
    parameter int MAX_LEVEL            = 2
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic [7:0]         rgb_in,
    input  logic               hblank_in,
    input  logic               vblank_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               btn_pause,
    input  logic               osd_open,
    input  logic               osd_pause_en,
    output logic               pause,
    output logic [7:0]         rgb_out,
    output logic               hblank_out,
    output logic               vblank_out,
    output logic               hs_out,
    output logic               vs_out,
    output logic [LEVEL_W-1:0] dim_level
);

    localparam int CNT_W = cnt_width(DIM_DELAY_FRAMES, FADE_FRAMES_PER_STEP);

    // A zero delay means the first counted tick already ends the wait.
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (DIM_DELAY_FRAMES == 0) ? '0 : CNT_W'(DIM_DELAY_FRAMES - 1);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);
`ifdef PAUSE_FADE_RAMP_EN
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_FRAMES_PER_STEP - 1);
`endif

    logic               btn_q;
    logic               toggle;
    logic               toggle_nxt;
    logic               frame_tick;
    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [LEVEL_W-1:0] level;

    pf_frame_tick u_frame_tick (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .vblank_in  (vblank_in),
        .frame_tick (frame_tick)
    );

    // Next toggle value: flips once per rising edge of the button level.
    always_comb begin
        toggle_nxt = toggle ^ (btn_pause & ~btn_q);
    end

    // Button edge history, pause toggle and registered combined pause.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q  <= 1'b0;
            toggle <= 1'b0;
            pause  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, regardless of statement order.
            btn_q  <= btn_pause;
            toggle <= toggle_nxt;
            pause  <= toggle_nxt | (osd_open & osd_pause_en);
        end
    end

    // Dim-timer FSM: only the user toggle drives it; the level changes only on
    // frame ticks so a frame is never torn between two brightness levels.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            frame_cnt <= '0;
            level     <= '0;
        end else if (!toggle) begin
            state     <= RUN;
            frame_cnt <= '0;
            if (frame_tick) begin
                level <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    // Entry into WAIT is immediate; a coincident tick is not counted.
                    state     <= WAIT;
                    frame_cnt <= '0;
                    if (frame_tick) begin
                        level <= '0;
                    end
                end
                WAIT: begin
                    if (frame_tick) begin
                        level <= '0;
                        if (frame_cnt == WAIT_LAST) begin
                            frame_cnt <= '0;
`ifdef PAUSE_FADE_RAMP_EN
                            state     <= FADE;
`else
                            state     <= DIM;
                            level     <= MAX_LVL;
`endif
                        end else if (frame_cnt != '1) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
`ifdef PAUSE_FADE_RAMP_EN
                FADE: begin
                    if (frame_tick) begin
                        if (frame_cnt == STEP_LAST) begin
                            frame_cnt <= '0;
                            level     <= level + 1'b1;
                            if (level + 1'b1 == MAX_LVL) begin
                                state <= DIM;
                            end
                        end else if (frame_cnt != '1) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
`endif
                DIM: begin
                    if (frame_tick) begin
                        level <= MAX_LVL;
                    end
                end
                default: begin
                    state     <= RUN;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

    assign dim_level = level;

    // One-pixel video re-timing with dimming and forced black in blanking.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out    <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
        end else if (ce_pix) begin
            rgb_out    <= (hblank_in | vblank_in) ? 8'h00 : dim_rgb332(rgb_in, level);
            hblank_out <= hblank_in;
            vblank_out <= vblank_in;
            hs_out     <= hs_in;
            vs_out     <= vs_in;
        end
    end

endmodule

// File: tb/tb_pause_fade.sv
// tb_pause_fade: scoreboard bench for pause_fade with DIM_DELAY_FRAMES=3,
// FADE_FRAMES_PER_STEP=2, MAX_LEVEL=2. The driver pushes the expected
// re-timed pixel for every ce_pix; a monitor pops and compares one pixel later.
module tb_pause_fade;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic [7:0] rgb_in;
    logic       hblank_in, vblank_in, hs_in, vs_in;
    logic       btn_pause, osd_open, osd_pause_en;
    logic       pause;
    logic [7:0] rgb_out;
    logic       hblank_out, vblank_out, hs_out, vs_out;
    logic [1:0] dim_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rgb;
        logic [3:0] flags;  // {hblank, vblank, hs, vs}
        logic [1:0] lvl;
    } exp_t;

    exp_t sb_q[$];

    // Hand-computed pixel values: [level][pattern]
    // FF=111_111_11, B6=101_101_10, 49=010_010_01, E3=111_000_11
    logic [7:0] exp_tab [0:2][0:3] = '{
        '{8'hFF, 8'hB6, 8'h49, 8'hE3},
        '{8'h6D, 8'h49, 8'h24, 8'h61},
        '{8'h24, 8'h24, 8'h00, 8'h20}
    };

    pause_fade #(
        .DIM_DELAY_FRAMES     (3),
        .FADE_FRAMES_PER_STEP (2),
        .MAX_LEVEL            (2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .rgb_in       (rgb_in),
        .hblank_in    (hblank_in),
        .vblank_in    (vblank_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .btn_pause    (btn_pause),
        .osd_open     (osd_open),
        .osd_pause_en (osd_pause_en),
        .pause        (pause),
        .rgb_out      (rgb_out),
        .hblank_out   (hblank_out),
        .vblank_out   (vblank_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .dim_level    (dim_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applied level after the k-th counted tick of a continuous pause.
    function automatic logic [1:0] ramp_level(input int k);
`ifdef PAUSE_FADE_RAMP_EN
        if (k >= 7) return 2'd2;
        if (k >= 5) return 2'd1;
        return 2'd0;
`else
        return (k >= 3) ? 2'd2 : 2'd0;
`endif
    endfunction

    // Drive one pixel (ce_pix for one clk, then one idle clk) and queue its expectation.
    task automatic drive_pixel(input int idx, input logic hb, input logic vb,
                               input logic hs, input logic vs,
                               input logic [1:0] lvl_px, input logic [1:0] lvl_dim,
                               input bit drop_btn);
        exp_t e;
        @(negedge clk_sys);
        rgb_in    = exp_tab[0][idx];
        hblank_in = hb;
        vblank_in = vb;
        hs_in     = hs;
        vs_in     = vs;
        ce_pix    = 1'b1;
        if (drop_btn) btn_pause = 1'b0;
        e.rgb   = (hb | vb) ? 8'h00 : exp_tab[lvl_px][idx];
        e.flags = {hb, vb, hs, vs};
        e.lvl   = lvl_dim;
        sb_q.push_back(e);
        @(negedge clk_sys);
        ce_pix = 1'b0;
    endtask

    // 4 lines of 8 pixels: 3 active lines then 1 vblank line; last 2 pixels
    // of each line in hblank. The tick lands on the first vblank pixel.
    task automatic drive_frame(input logic [1:0] lvl_before, input logic [1:0] lvl_after,
                               input bit press_at_tick);
        for (int line = 0; line < 4; line++) begin
            for (int px = 0; px < 8; px++) begin
                logic vb;
                vb = (line == 3);
                if (press_at_tick && vb && px == 0) btn_pause = 1'b1;
                drive_pixel((line + px) % 4, px >= 6, vb, px == 7, vb && px < 2,
                            lvl_before, vb ? lvl_after : lvl_before,
                            press_at_tick && vb && px == 0);
            end
        end
    endtask

    // Monitor: compare each re-timed pixel one clock after its ce_pix.
    initial begin
        forever begin
            @(posedge clk_sys);
            if (ce_pix === 1'b1 && reset_n === 1'b1) begin
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: output pixel with no expectation at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rgb_out", rgb_out, e.rgb);
                    check("sync_blank", {hblank_out, vblank_out, hs_out, vs_out}, e.flags);
                    check("dim_level", dim_level, e.lvl);
                end
            end
        end
    end

    initial begin
        logic [1:0] lvl, nl, coinc_lvl;
        reset_n = 1'b0; ce_pix = 1'b0; rgb_in = 8'hFF;
        hblank_in = 1'b0; vblank_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        btn_pause = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_rgb", rgb_out, 8'h00);
        check("rst_hblank", hblank_out, 1'b1);
        check("rst_vblank", vblank_out, 1'b1);
        check("rst_hs_vs", {hs_out, vs_out}, 2'b00);
        check("rst_pause", pause, 1'b0);
        check("rst_dim", dim_level, 2'd0);

        // Release, a few active pixels, then an asynchronous mid-line reset
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_pixel(0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        rgb_in = 8'hFF;
        reset_n = 1'b0;
        #1;
        check("midrst_rgb", rgb_out, 8'h00);
        check("midrst_hblank", hblank_out, 1'b1);
        check("midrst_vblank", vblank_out, 1'b1);
        check("midrst_pause", pause, 1'b0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        drive_frame(2'd0, 2'd0, 1'b0);

        // Press and hold for 100 frames: one toggle, delayed ramp to MAX_LEVEL
        btn_pause = 1'b1;
        @(negedge clk_sys);
        check("press_pause", pause, 1'b1);
        lvl = 2'd0;
        for (int k = 1; k <= 100; k++) begin
            nl = ramp_level(k);
            drive_frame(lvl, nl, 1'b0);
            check("hold_pause", pause, 1'b1);
            lvl = nl;
        end
        btn_pause = 1'b0;
        @(negedge clk_sys);
        check("release_pause", pause, 1'b1);

        // Unpause at level 2: dimmed until the next tick, then full brightness
        btn_pause = 1'b1;
        @(negedge clk_sys);
        btn_pause = 1'b0;
        check("unpause", pause, 1'b0);
        drive_frame(2'd2, 2'd0, 1'b0);
        drive_frame(2'd0, 2'd0, 1'b0);

        // OSD pause: pause output only, dim timer idle
        osd_open = 1'b1; osd_pause_en = 1'b1;
        @(negedge clk_sys);
        check("osd_pause", pause, 1'b1);
        repeat (10) drive_frame(2'd0, 2'd0, 1'b0);
        check("osd_pause_hold", pause, 1'b1);
        osd_pause_en = 1'b0;
        @(negedge clk_sys);
        check("osd_pause_dis", pause, 1'b0);
        osd_open = 1'b0;

        // Toggle rising coincident with a tick: that tick is not counted
`ifdef PAUSE_FADE_RAMP_EN
        coinc_lvl = 2'd0;
`else
        coinc_lvl = 2'd2;
`endif
        drive_frame(2'd0, 2'd0, 1'b1);
        check("coinc_pause", pause, 1'b1);
        drive_frame(2'd0, 2'd0, 1'b0);
        drive_frame(2'd0, 2'd0, 1'b0);
        drive_frame(2'd0, coinc_lvl, 1'b0);
        btn_pause = 1'b1;
        @(negedge clk_sys);
        btn_pause = 1'b0;
        check("coinc_unpause", pause, 1'b0);
        drive_frame(coinc_lvl, 2'd0, 1'b0);
        drive_frame(2'd0, 2'd0, 1'b0);

        @(negedge clk_sys);
        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
